regc_write_arbiter: RTL



---
 rtl/regc_write_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/regc_write_arbiter.sv
// Register-C write-port arbiter.
// Shares the register-C write port between four requesters (ALU writeback,
// load writeback, immediate/move path, special-register path). Requester i
// maps directly to register-C number mux select value i. Arbitration is
// round-robin. A holder may keep the grant for up to MAX_HOLD consecutive
// cycles by asserting lock. Every output comes straight from a flop, so
// there is no combinational path from the inputs to the outputs.

module regc_write_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] lock,
  input  logic       stall,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       wr_en,
  output logic       busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  // Returns the first set request bit, searching from p upward (mod 4).
  // The caller only uses the result when at least one request bit is set.
  function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] w;
    logic       found;
    w     = p;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return w;
  endfunction

  state_t     state_r,    state_s;
  logic [1:0] ptr_r,      ptr_s;
  logic [3:0] hold_cnt_r, hold_cnt_s;
  logic [3:0] gnt_r,      gnt_s;
  logic [1:0] sel_r,      sel_s;
  logic       wr_en_r,    wr_en_s;
  logic       busy_r,     busy_s;

  logic [1:0] holder_s;
  logic [1:0] next_ptr_s;
  logic [1:0] winner_s;
  logic       keep_s;

  // The holder is whichever requester sel points at. Decide here whether it
  // keeps the grant and which requester would win a fresh arbitration.
  always_comb begin
    holder_s   = sel_r;
    next_ptr_s = sel_r + 2'd1;
    keep_s     = req[holder_s] & lock[holder_s] & (hold_cnt_r < MAX_HOLD_C);
    if (state_r == GRANT) begin
      winner_s = pick_winner(req, next_ptr_s);
    end else begin
      winner_s = pick_winner(req, ptr_r);
    end
  end

  // Next-state and next-output logic. Stall freezes everything and only
  // pulls the write enable low.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    hold_cnt_s = hold_cnt_r;
    gnt_s      = gnt_r;
    sel_s      = sel_r;
    busy_s     = busy_r;
    wr_en_s    = 1'b0;
    if (stall) begin
      wr_en_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|req) begin
            state_s    = GRANT;
            gnt_s      = 4'b0001 << winner_s;
            sel_s      = winner_s;
            hold_cnt_s = 4'd1;
            wr_en_s    = 1'b1;
            busy_s     = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        GRANT: begin
          if (keep_s) begin
            hold_cnt_s = hold_cnt_r + 4'd1;
            wr_en_s    = 1'b1;
          end else begin
            // Release. The holder moves to the lowest priority. A waiting
            // requester takes over in the same edge, so no bubble cycle.
            ptr_s = next_ptr_s;
            if (|req) begin
              state_s    = GRANT;
              gnt_s      = 4'b0001 << winner_s;
              sel_s      = winner_s;
              hold_cnt_s = 4'd1;
              wr_en_s    = 1'b1;
              busy_s     = 1'b1;
            end else begin
              state_s    = IDLE;
              gnt_s      = 4'b0000;
              hold_cnt_s = 4'd0;
              busy_s     = 1'b0;
            end
          end
        end
        default: begin
          state_s    = IDLE;
          ptr_s      = 2'd0;
          hold_cnt_s = 4'd0;
          gnt_s      = 4'b0000;
          sel_s      = 2'd0;
          busy_s     = 1'b0;
        end
      endcase
    end
  end

  // State and output registers. Reset takes priority over stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      ptr_r      <= 2'd0;
      hold_cnt_r <= 4'd0;
      gnt_r      <= 4'b0000;
      sel_r      <= 2'd0;
      wr_en_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      hold_cnt_r <= hold_cnt_s;
      gnt_r      <= gnt_s;
      sel_r      <= sel_s;
      wr_en_r    <= wr_en_s;
      busy_r     <= busy_s;
    end
  end

  assign gnt   = gnt_r;
  assign sel   = sel_r;
  assign wr_en = wr_en_r;
  assign busy  = busy_r;

  regc_write_arbiter_chk u_chk (
    .clk   (clk),
    .reset (reset),
    .gnt   (gnt_r),
    .sel   (sel_r),
    .wr_en (wr_en_r),
    .busy  (busy_r)
  );

endmodule

// Output invariants of the register-C write arbiter.
module regc_write_arbiter_chk (
  input logic       clk,
  input logic       reset,
  input logic [3:0] gnt,
  input logic [1:0] sel,
  input logic       wr_en,
  input logic       busy
);

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
  a_busy_gnt:    assert property (@(posedge clk) disable iff (reset) busy == (|gnt));
  a_sel_match:   assert property (@(posedge clk) disable iff (reset) (gnt != 4'b0000) |-> gnt[sel]);
  a_wr_busy:     assert property (@(posedge clk) disable iff (reset) wr_en |-> busy);

endmodule
